// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped PWM/timer block and the memory that
// shares its load path: access widths, register offsets and lane helpers.
package mmio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PWM_W  = 8;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Word offsets (address[3:2]) inside the register window
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_DUTY   = 2'd1;
    localparam logic [1:0] OFF_MICROS = 2'd2;
    localparam logic [1:0] OFF_MILLIS = 2'd3;

    // True when funct3 is a legal access of that kind and the lane is aligned for it
    function automatic logic access_ok(input logic [2:0] f3,
                                       input logic [1:0] lane,
                                       input logic       is_store);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !lane[0];
            F3_HU:   ok = !is_store && !lane[0];
            F3_W:    ok = (lane == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Right-align and extend the addressed lane of a word; illegal accesses read 0
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        lane);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        r = '0;
        if (access_ok(f3, lane, 1'b0)) begin
            case (f3)
                F3_B:    r = {{24{b[7]}}, b};
                F3_BU:   r = {24'h0, b};
                F3_H:    r = {{16{h[15]}}, h};
                F3_HU:   r = {16'h0, h};
                F3_W:    r = word;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Merge right-aligned store data into the old word at the addressed lane
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] data,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        lane);
        logic [DATA_W-1:0] r;
        r = old;
        case (f3)
            F3_B: r[{lane, 3'b000} +: 8] = data[7:0];
            F3_H: begin
                if (lane[1]) r[31:16] = data[15:0];
                else         r[15:0]  = data[15:0];
            end
            F3_W:    r = data;
            default: r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_pwm_timer_pwm_channel.sv
// One PWM output: compares the shared PWM count against this channel's duty.
module pwm_channel
    import mmio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PWM_W-1:0] duty,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             out
);

    // Registered compare; duty 0 never fires, duty 255 is low on count 255 only
    always_ff @(posedge clk) begin
        if (reset) out <= 1'b0;
        else       out <= en && (pwm_cnt < duty);
    end

endmodule

// File: rtl/mmio_pwm_timer.sv
// Memory-mapped PWM/timer peripheral on the core's dmem port: CTRL, four 8-bit
// PWM duties, and free-running microsecond/millisecond counters.
module mmio_pwm_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFE0,
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned PWM_DIV     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       dmem_address,
    input  logic              dmem_wren,
    input  logic [31:0]       dmem_data_in,
    input  logic [2:0]        funct3,
    output logic [31:0]       dmem_data_out,
    output logic              led,
    output logic              red,
    output logic              green,
    output logic              blue
);

    // Prescaler sizing; degenerate parameters collapse to a divide-by-one
    localparam int unsigned US_DIV  = (CLK_FREQ_HZ / 1_000_000 == 0) ? 1 : CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned US_W    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int unsigned MS_DIV  = 1000;
    localparam int unsigned MS_W    = 10;
    localparam int unsigned PDIV    = (PWM_DIV == 0) ? 1 : PWM_DIV;
    localparam int unsigned PDIV_W  = (PDIV > 1) ? $clog2(PDIV) : 1;

    localparam logic [US_W-1:0]   US_LAST   = US_W'(US_DIV - 1);
    localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_DIV - 1);
    localparam logic [PDIV_W-1:0] PDIV_LAST = PDIV_W'(PDIV - 1);

    // Architectural state
    logic                pwm_en;
    logic [DATA_W-1:0]   duty;
    logic [DATA_W-1:0]   micros;
    logic [DATA_W-1:0]   millis;
    logic [US_W-1:0]     us_pre;
    logic [MS_W-1:0]     ms_pre;
    logic [PDIV_W-1:0]   pwm_div;
    logic [PWM_W-1:0]    pwm_cnt;

    // Decode / datapath nets
    logic                hit;
    logic [1:0]          off;
    logic [1:0]          lane;
    logic [DATA_W-1:0]   read_word;
    logic [DATA_W-1:0]   merged;
    logic                wr_ok;
    logic                ctrl_wr;
    logic                duty_wr;
    logic                clr;
    logic                us_tick;
    logic                ms_wrap;

    // Address decode and store qualification
    always_comb begin
        hit     = (dmem_address[31:4] == BASE_ADDR[31:4]);
        off     = dmem_address[3:2];
        lane    = dmem_address[1:0];
        wr_ok   = dmem_wren && hit && access_ok(funct3, lane, 1'b1);
        ctrl_wr = wr_ok && (off == OFF_CTRL);
        duty_wr = wr_ok && (off == OFF_DUTY);
    end

    // Current value of the addressed word; clr always reads back as 0
    always_comb begin
        read_word = '0;
        case (off)
            OFF_CTRL:   read_word = {31'h0, pwm_en};
            OFF_DUTY:   read_word = duty;
            OFF_MICROS: read_word = micros;
            OFF_MILLIS: read_word = millis;
            default:    read_word = '0;
        endcase
    end

    // Store merge: partial writes keep the untouched lanes of the old word
    always_comb begin
        merged = store_merge(read_word, dmem_data_in, funct3, lane);
        clr    = ctrl_wr && merged[1];
    end

    // Prescaler wrap detection
    always_comb begin
        us_tick = (us_pre == US_LAST);
        ms_wrap = us_tick && (ms_pre == MS_LAST);
    end

    // CTRL and DUTY registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_en <= 1'b0;
            duty   <= '0;
        end else begin
            if (ctrl_wr) pwm_en <= merged[0];
            if (duty_wr) duty   <= merged;
        end
    end

    // Free-running time base; a clr store wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            us_pre <= '0;
            ms_pre <= '0;
            micros <= '0;
            millis <= '0;
        end else begin
            us_pre <= us_tick ? '0 : us_pre + US_W'(1);
            if (us_tick) begin
                micros <= micros + 32'd1;
                ms_pre <= ms_wrap ? '0 : ms_pre + MS_W'(1);
                if (ms_wrap) millis <= millis + 32'd1;
            end
        end
    end

    // PWM period counter, parked at zero while disabled
    always_ff @(posedge clk) begin
        if (reset || !pwm_en) begin
            pwm_div <= '0;
            pwm_cnt <= '0;
        end else if (pwm_div == PDIV_LAST) begin
            pwm_div <= '0;
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end else begin
            pwm_div <= pwm_div + PDIV_W'(1);
        end
    end

    // Registered load path; zero when not selected so the memory can OR it in
    always_ff @(posedge clk) begin
        if (reset)    dmem_data_out <= '0;
        else if (hit) dmem_data_out <= load_extend(read_word, funct3, lane);
        else          dmem_data_out <= '0;
    end

    pwm_channel u_led (
        .clk     (clk),
        .reset   (reset),
        .en      (pwm_en),
        .duty    (duty[7:0]),
        .pwm_cnt (pwm_cnt),
        .out     (led)
    );

    pwm_channel u_red (
        .clk     (clk),
        .reset   (reset),
        .en      (pwm_en),
        .duty    (duty[15:8]),
        .pwm_cnt (pwm_cnt),
        .out     (red)
    );

    pwm_channel u_green (
        .clk     (clk),
        .reset   (reset),
        .en      (pwm_en),
        .duty    (duty[23:16]),
        .pwm_cnt (pwm_cnt),
        .out     (green)
    );

    pwm_channel u_blue (
        .clk     (clk),
        .reset   (reset),
        .en      (pwm_en),
        .duty    (duty[31:24]),
        .pwm_cnt (pwm_cnt),
        .out     (blue)
    );

endmodule
